// File: rtl/lockstep_pkg.sv
// Shared types and constants for the cluster lockstep controller.
// Latency: none, this file holds definitions only.
// Backpressure: none, this file holds definitions only.
package lockstep_pkg;

  // Register word indices, decoded from add_i[4:2]
  localparam logic [2:0] REG_MODE_REQ    = 3'd0;
  localparam logic [2:0] REG_MODE_STATUS = 3'd1;
  localparam logic [2:0] REG_PENDING     = 3'd2;
  localparam logic [2:0] REG_MISM_STATUS = 3'd3;
  localparam logic [2:0] REG_MISM_CNT    = 3'd4;
  localparam logic [2:0] REG_IRQ_EN      = 3'd5;

  // Response opcode
  localparam logic R_OPC_OK  = 1'b0;
  localparam logic R_OPC_ERR = 1'b1;

  // Per-pair lockstep state
  typedef enum logic [1:0] {
    SPLIT      = 2'd0,
    ENTER_WAIT = 2'd1,
    LOCKED     = 2'd2,
    EXIT_WAIT  = 2'd3
  } lockstep_state_e;

  // Response payload computed in the grant cycle and registered for the next
  typedef struct packed {
    logic        opc;
    logic [31:0] rdata;
  } rsp_t;

endpackage

// File: rtl/lockstep_pair_fsm.sv
// Per-pair lockstep sequencer: switches a core pair in/out of lockstep at barriers.
// Latency: mode/pending registered, change one cycle after the deciding input.
// Backpressure: none, inputs are sampled every cycle.
module lockstep_pair_fsm
  import lockstep_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mode_req,
  input  logic bm,
  input  logic mismatch,
  output logic mode,
  output logic pending,
  output logic force_clear_req
);

  lockstep_state_e state;

  // A mismatch only counts while the pair is actually running in lockstep.
  assign force_clear_req = mismatch & mode;

  // mode_req is the value MODE_REQ takes at this edge, so a bus write is seen
  // in its own grant cycle; a barrier in that same cycle finds the pair still
  // in SPLIT/LOCKED and is therefore ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= SPLIT;
      mode    <= 1'b0;
      pending <= 1'b0;
    end else if (force_clear_req) begin
      state   <= SPLIT;
      mode    <= 1'b0;
      pending <= 1'b0;
    end else begin
      case (state)
        SPLIT: begin
          if (mode_req) begin
            state   <= ENTER_WAIT;
            pending <= 1'b1;
          end
        end
        ENTER_WAIT: begin
          if (!mode_req) begin
            state   <= SPLIT;
            pending <= 1'b0;
          end else if (bm) begin
            state   <= LOCKED;
            mode    <= 1'b1;
            pending <= 1'b0;
          end
        end
        LOCKED: begin
          if (!mode_req) begin
            state   <= EXIT_WAIT;
            pending <= 1'b1;
          end
        end
        EXIT_WAIT: begin
          if (mode_req) begin
            state   <= LOCKED;
            pending <= 1'b0;
          end else if (bm) begin
            state   <= SPLIT;
            mode    <= 1'b0;
            pending <= 1'b0;
          end
        end
        default: begin
          state   <= SPLIT;
          mode    <= 1'b0;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lockstep_ctrl.sv
// Lockstep controller slave: mode registers, per-pair sequencers, mismatch counter and IRQ.
// Latency: gnt combinational, response registered one cycle after grant; irq two cycles after mismatch.
// Backpressure: none, every request is granted in the cycle it is presented.
module lockstep_ctrl
  import lockstep_pkg::*;
#(
  parameter int NB_CORES  = 8,
  parameter int ID_WIDTH  = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic [31:0]              add_i,
  input  logic                     wen_i,
  input  logic [31:0]              wdata_i,
  input  logic [3:0]               be_i,
  input  logic [ID_WIDTH-1:0]      id_i,
  output logic                     gnt_o,
  output logic                     r_valid_o,
  output logic                     r_opc_o,
  output logic [ID_WIDTH-1:0]      r_id_o,
  output logic [31:0]              r_rdata_o,
  input  logic [NB_CORES-1:0]      barrier_matched_i,
  input  logic [NB_CORES/2-1:0]    mismatch_i,
  output logic [NB_CORES/2-1:0]    lockstep_mode_o,
  output logic                     irq_o
);

  localparam int NB_PAIRS = NB_CORES / 2;
  localparam logic [32:0] CNT_MAX = {{(33-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

  logic [2:0]           reg_idx;
  logic                 wr_en;
  logic                 rd_en;
  logic [NB_PAIRS-1:0]  bm;
  logic [NB_PAIRS-1:0]  pending;
  logic [NB_PAIRS-1:0]  qual_mism;
  logic [NB_PAIRS-1:0]  mode_req_q, mode_req_d;
  logic [NB_PAIRS-1:0]  mism_status_q, mism_status_d;
  logic [NB_PAIRS-1:0]  irq_en_q, irq_en_d;
  logic [CNT_WIDTH-1:0] mism_cnt_q, mism_cnt_d;
  logic [CNT_WIDTH-1:0] cnt_base;
  logic [31:0]          qual_pc;
  logic [32:0]          cnt_sum;
  logic [31:0]          rd_word;
  rsp_t                 rsp_d;
  logic                 unused_bits;

  // Only word index bits are decoded and accesses are always full-word.
  assign unused_bits = ^{add_i[31:5], add_i[1:0], be_i, wdata_i};

  assign gnt_o   = req_i;
  assign reg_idx = add_i[4:2];
  assign wr_en   = req_i & ~wen_i;
  assign rd_en   = req_i & wen_i;

  for (genvar p = 0; p < NB_PAIRS; p++) begin : g_pair
    assign bm[p] = barrier_matched_i[2*p] & barrier_matched_i[2*p+1];

    lockstep_pair_fsm u_fsm (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .mode_req        (mode_req_d[p]),
      .bm              (bm[p]),
      .mismatch        (mismatch_i[p]),
      .mode            (lockstep_mode_o[p]),
      .pending         (pending[p]),
      .force_clear_req (qual_mism[p])
    );
  end

  // Next register values: bus write first, then hardware mismatch updates on top.
  always_comb begin
    mode_req_d = mode_req_q;
    if (wr_en && reg_idx == REG_MODE_REQ) mode_req_d = wdata_i[NB_PAIRS-1:0];
    mode_req_d = mode_req_d & ~qual_mism;

    mism_status_d = mism_status_q;
    if (wr_en && reg_idx == REG_MISM_STATUS) mism_status_d = mism_status_q & ~wdata_i[NB_PAIRS-1:0];
    mism_status_d = mism_status_d | qual_mism;

    irq_en_d = irq_en_q;
    if (wr_en && reg_idx == REG_IRQ_EN) irq_en_d = wdata_i[NB_PAIRS-1:0];
  end

  // Saturating mismatch counter; a same-cycle clear restarts from zero before adding.
  always_comb begin
    qual_pc = '0;
    for (int i = 0; i < NB_PAIRS; i++) qual_pc = qual_pc + 32'(qual_mism[i]);
    cnt_base   = (wr_en && reg_idx == REG_MISM_CNT) ? '0 : mism_cnt_q;
    cnt_sum    = 33'(cnt_base) + 33'(qual_pc);
    mism_cnt_d = (cnt_sum > CNT_MAX) ? '1 : cnt_sum[CNT_WIDTH-1:0];
  end

  // Read mux and opcode for the current request.
  always_comb begin
    rd_word   = '0;
    rsp_d     = '0;
    rsp_d.opc = R_OPC_OK;
    case (reg_idx)
      REG_MODE_REQ:    rd_word[NB_PAIRS-1:0]  = mode_req_q;
      REG_MODE_STATUS: rd_word[NB_PAIRS-1:0]  = lockstep_mode_o;
      REG_PENDING:     rd_word[NB_PAIRS-1:0]  = pending;
      REG_MISM_STATUS: rd_word[NB_PAIRS-1:0]  = mism_status_q;
      REG_MISM_CNT:    rd_word[CNT_WIDTH-1:0] = mism_cnt_q;
      REG_IRQ_EN:      rd_word[NB_PAIRS-1:0]  = irq_en_q;
      default:         rsp_d.opc              = R_OPC_ERR;
    endcase
    if (rd_en) rsp_d.rdata = rd_word;
  end

  // Register state and interrupt; irq follows the registered flags one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_req_q    <= '0;
      mism_status_q <= '0;
      irq_en_q      <= '0;
      mism_cnt_q    <= '0;
      irq_o         <= 1'b0;
    end else begin
      mode_req_q    <= mode_req_d;
      mism_status_q <= mism_status_d;
      irq_en_q      <= irq_en_d;
      mism_cnt_q    <= mism_cnt_d;
      irq_o         <= |(mism_status_q & irq_en_q);
    end
  end

  // Registered bus response, one per granted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_opc_o   <= R_OPC_OK;
      r_id_o    <= '0;
      r_rdata_o <= '0;
    end else begin
      r_valid_o <= req_i;
      r_opc_o   <= req_i ? rsp_d.opc : R_OPC_OK;
      r_id_o    <= req_i ? id_i : '0;
      r_rdata_o <= rsp_d.rdata;
    end
  end

endmodule
